// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 16x-oversampled UART receiver. Data width, parity mode and stop
//            bit count are configurable. Good words go into a first-word-
//            fall-through FIFO that is read through a valid/ready handshake.
//            Framing, parity and overrun errors are held in sticky flags.
//            The most recent good word is also kept in a separate register.
// Ports    : clk        - system clock
//            rst        - asynchronous reset, active low
//            rx_serial  - asynchronous serial line, idle high
//            rd_data    - FIFO head word
//            rd_valid   - FIFO not empty
//            rd_ready   - consumer pops the head when rd_valid & rd_ready
//            fifo_count - current FIFO occupancy
//            last_byte  - most recent good frame
//            frame_err  - sticky: a stop bit was sampled low
//            parity_err - sticky: parity mismatch
//            overrun    - sticky: a good frame was dropped on a full FIFO
//            err_clr    - synchronous clear of all sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_serial,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DATA_BITS-1:0]          last_byte,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    // Reset value of last_byte: alternating bits with the MSB set.
    function automatic logic [DATA_BITS-1:0] f_alt_pattern();
        logic [DATA_BITS-1:0] v;
        for (int i = 0; i < DATA_BITS; i++) begin
            v[i] = (((DATA_BITS - 1 - i) % 2) == 0);
        end
        return v;
    endfunction

    localparam int                   c_DIV       = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int                   c_DIV_W     = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam int                   c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]        c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam int                   c_BW        = $clog2(DATA_BITS);
    localparam logic [c_BW-1:0]      c_BIT_LAST  = c_BW'(DATA_BITS - 1);
    localparam logic                 c_STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [DATA_BITS-1:0] c_LAST_RST  = f_alt_pattern();

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and start-edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_live;
    logic                   r_prev_rx;
    logic                   w_rx;
    logic                   w_start_edge;

    // r_live marks when the synchroniser output reflects the real line
    // rather than its reset fill. r_prev_rx stays 0 until then, so a line
    // held low across reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= '1;
            r_live    <= '0;
            r_prev_rx <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_serial};
            r_live    <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_prev_rx <= w_rx & r_live[SYNC_STAGES-1];
        end
    end

    assign w_rx         = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_prev_rx & ~w_rx;

    // ------------------------------------------------------------------
    // Oversample tick and receive FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [3:0]          r_phase;
    logic [c_BW-1:0]     r_bit_cnt;
    logic                r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                r_par;

    logic w_tick;
    logic w_mid;
    logic w_end;
    logic w_realign;
    logic w_shift_en;
    logic w_par_en;
    logic w_done;
    logic w_ferr_evt;

    assign w_tick = (r_div_cnt == c_DIV_LAST);
    assign w_mid  = w_tick & (r_phase == 4'd7);
    assign w_end  = w_tick & (r_phase == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_realign   = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_done      = 1'b0;
        w_ferr_evt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_realign   = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A start bit that is already high again at mid-bit is a glitch.
                if (w_mid && w_rx) begin
                    w_state_nxt = S_IDLE;
                end else if (w_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = w_mid;
                if (w_end && (r_bit_cnt == c_BIT_LAST)) begin
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                w_par_en = w_mid;
                if (w_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // The frame is closed at mid-point of the last stop bit so the
                // FSM is back in IDLE in time for a back-to-back start bit.
                if (w_mid) begin
                    if (!w_rx) begin
                        w_ferr_evt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end else if (r_stop_cnt == c_STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt  <= '0;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            if (w_realign || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state != S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (w_end) begin
                r_stop_cnt <= 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            end

            if (w_par_en) begin
                r_par <= w_rx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame evaluation
    // ------------------------------------------------------------------
    logic w_ones_odd;
    logic w_par_ok;
    logic w_good;
    logic w_par_evt;

    assign w_ones_odd = (^r_shift) ^ r_par;

    always_comb begin
        w_par_ok = 1'b1;
        if (PARITY == 1) begin
            w_par_ok = w_ones_odd;
        end else if (PARITY == 2) begin
            w_par_ok = ~w_ones_odd;
        end
    end

    assign w_good    = w_done & w_par_ok;
    assign w_par_evt = w_done & ~w_par_ok;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ovr_evt;

    assign w_full    = (r_count == c_FULL);
    assign w_pop     = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_ovr_evt = w_good & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data    = r_mem[r_rd_ptr];
    assign rd_valid   = (r_count != '0);
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Last good word and sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_last_byte;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_byte  <= c_LAST_RST;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_good) begin
                r_last_byte <= r_shift;
            end

            if (w_ferr_evt) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            if (w_par_evt) begin
                r_parity_err <= 1'b1;
            end else if (err_clr) begin
                r_parity_err <= 1'b0;
            end

            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign last_byte  = r_last_byte;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo. Three instances:
//            A = 8N1 with a 4-entry FIFO, B = 8E1, C = 7N2. One bit = 32 clks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic err_clr;

    logic       rx_a, ready_a, valid_a, ferr_a, perr_a, ovr_a;
    logic [7:0] data_a, last_a;
    logic [2:0] count_a;

    logic       rx_b, ready_b, valid_b, ferr_b, perr_b, ovr_b;
    logic [7:0] data_b, last_b;
    logic [4:0] count_b;

    logic       rx_c, ready_c, valid_c, ferr_c, perr_c, ovr_c;
    logic [6:0] data_c, last_c;
    logic [4:0] count_c;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_a[$];
    logic [6:0] q_c[$];

    uart_rx_fifo #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .rx_serial(rx_a), .rd_data(data_a), .rd_valid(valid_a),
        .rd_ready(ready_a), .fifo_count(count_a), .last_byte(last_a), .frame_err(ferr_a),
        .parity_err(perr_a), .overrun(ovr_a), .err_clr(err_clr));

    uart_rx_fifo #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .rx_serial(rx_b), .rd_data(data_b), .rd_valid(valid_b),
        .rd_ready(ready_b), .fifo_count(count_b), .last_byte(last_b), .frame_err(ferr_b),
        .parity_err(perr_b), .overrun(ovr_b), .err_clr(err_clr));

    uart_rx_fifo #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(16), .SYNC_STAGES(2)) u_c (
        .clk(clk), .rst(rst), .rx_serial(rx_c), .rd_data(data_c), .rd_valid(valid_c),
        .rd_ready(ready_c), .fifo_count(count_c), .last_byte(last_c), .frame_err(ferr_c),
        .parity_err(perr_c), .overrun(ovr_c), .err_clr(err_clr));

    // Record every word handed over by A and C.
    always @(negedge clk) begin
        if (rst && valid_a && ready_a) q_a.push_back(data_a);
        if (rst && valid_c && ready_c) q_c.push_back(data_c);
    end

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic bit_time();
        repeat (32) @(negedge clk);
    endtask

    // par_bit < 0 means no parity bit. The line is left at the last stop value.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int par_bit, input int nstop, input logic [1:0] stop_vals);
        @(negedge clk);
        set_rx(sel, 1'b0);
        bit_time();
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, data[i]);
            bit_time();
        end
        if (par_bit >= 0) begin
            set_rx(sel, par_bit[0]);
            bit_time();
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(sel, stop_vals[i]);
            bit_time();
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; err_clr = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
        checks++; if ({ferr_a, perr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ferr_a, perr_a, ovr_a}); end
        checks++; if (last_a !== 8'hAA) begin errors++; $display("FAIL reset_last_a: got %h want aa", last_a); end
        checks++; if (last_b !== 8'hAA) begin errors++; $display("FAIL reset_last_b: got %h want aa", last_b); end
        checks++; if (last_c !== 7'h55) begin errors++; $display("FAIL reset_last_c: got %h want 55", last_c); end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", valid_a); end
    endtask

    task automatic test_8n1();
        q_a.delete();
        ready_a = 1'b1;
        send_frame(0, 9'h055, 8, -1, 1, 2'b11);
        send_frame(0, 9'h0A3, 8, -1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL 8n1_words: got %0d want 2", q_a.size()); end
        checks++; if (q_a[0] !== 8'h55) begin errors++; $display("FAIL 8n1_first: got %h want 55", q_a[0]); end
        checks++; if (q_a[1] !== 8'hA3) begin errors++; $display("FAIL 8n1_second: got %h want a3", q_a[1]); end
        checks++; if (last_a !== 8'hA3) begin errors++; $display("FAIL 8n1_last: got %h want a3", last_a); end
        checks++; if ({ferr_a, perr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b want 000", {ferr_a, perr_a, ovr_a}); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL 8n1_count: got %0d want 0", count_a); end
    endtask

    task automatic test_parity();
        ready_b = 1'b0;
        send_frame(1, 9'h00F, 8, 0, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (count_b !== 5'd1) begin errors++; $display("FAIL par_good_count: got %0d want 1", count_b); end
        checks++; if (data_b !== 8'h0F) begin errors++; $display("FAIL par_good_data: got %h want 0f", data_b); end
        checks++; if (perr_b !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", perr_b); end
        send_frame(1, 9'h00F, 8, 1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (perr_b !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", perr_b); end
        checks++; if (count_b !== 5'd1) begin errors++; $display("FAIL par_bad_count: got %0d want 1", count_b); end
        send_frame(1, 9'h007, 8, 0, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (last_b !== 8'h0F) begin errors++; $display("FAIL par_bad_last: got %h want 0f", last_b); end
        send_frame(1, 9'h007, 8, 1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (count_b !== 5'd2) begin errors++; $display("FAIL par_odd_data_count: got %0d want 2", count_b); end
        checks++; if (last_b !== 8'h07) begin errors++; $display("FAIL par_odd_data_last: got %h want 07", last_b); end
    endtask

    task automatic test_frame_err();
        q_a.delete();
        ready_a = 1'b1;
        send_frame(0, 9'h07E, 8, -1, 1, 2'b00);
        repeat (5) bit_time();
        rx_a = 1'b1;
        repeat (2) bit_time();
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", ferr_a); end
        checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL ferr_no_push: got %0d words want 0", q_a.size()); end
        checks++; if (last_a !== 8'hA3) begin errors++; $display("FAIL ferr_last: got %h want a3", last_a); end
        send_frame(0, 9'h012, 8, -1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL ferr_recover_words: got %0d want 1", q_a.size()); end
        checks++; if (q_a[0] !== 8'h12) begin errors++; $display("FAIL ferr_recover_data: got %h want 12", q_a[0]); end
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", ferr_a); end
        pulse_clr();
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", ferr_a); end
    endtask

    task automatic test_overrun();
        ready_a = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send_frame(0, 9'(i), 8, -1, 1, 2'b11);
        end
        repeat (2) bit_time();
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d want 4", count_a); end
        checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", ovr_a); end
        checks++; if (last_a !== 8'h06) begin errors++; $display("FAIL ovr_last: got %h want 06", last_a); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (data_a !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d: got %h want %h", i, data_a, 8'(i)); end
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            @(negedge clk);
        end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b want 0", valid_a); end
    endtask

    task automatic test_full_pop();
        pulse_clr();
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL clr_overrun: got %b want 0", ovr_a); end
        ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(0, 9'h011 + 9'(i), 8, -1, 1, 2'b11);
        end
        repeat (2) bit_time();
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count_a); end
        // The fifth word is pushed on the 307th rising edge after the start bit.
        fork
            send_frame(0, 9'h015, 8, -1, 1, 2'b11);
            begin
                @(negedge clk);
                repeat (306) @(negedge clk);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        bit_time();
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d want 4", count_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL fullpop_overrun: got %b want 0", ovr_a); end
        checks++; if (last_a !== 8'h15) begin errors++; $display("FAIL fullpop_last: got %h want 15", last_a); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_a !== 8'h12 + 8'(i)) begin errors++; $display("FAIL fullpop_read%0d: got %h want %h", i, data_a, 8'h12 + 8'(i)); end
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_glitch_reset();
        q_a.delete();
        ready_a = 1'b1;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (2) bit_time();
        checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL glitch_words: got %0d want 0", q_a.size()); end
        checks++; if ({ferr_a, perr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL glitch_flags: got %b want 000", {ferr_a, perr_a, ovr_a}); end
        ready_a = 1'b0;
        send_frame(0, 9'h05A, 8, -1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL pre_reset_count: got %0d want 1", count_a); end
        // Partial 0x3C frame: start bit and bits 0..2, then reset inside bit 3.
        @(negedge clk);
        rx_a = 1'b0; bit_time();
        rx_a = 1'b0; bit_time();
        rx_a = 1'b0; bit_time();
        rx_a = 1'b1; bit_time();
        rx_a = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", count_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", valid_a); end
        checks++; if (last_a !== 8'hAA) begin errors++; $display("FAIL midreset_last: got %h want aa", last_a); end
        rst = 1'b1;
        repeat (12) bit_time();
        rx_a = 1'b1;
        repeat (2) bit_time();
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL low_across_reset: got frame_err %b want 0", ferr_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL low_across_reset_count: got %0d want 0", count_a); end
        q_a.delete();
        ready_a = 1'b1;
        send_frame(0, 9'h03C, 8, -1, 1, 2'b11);
        repeat (2) bit_time();
        checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL after_reset_words: got %0d want 1", q_a.size()); end
        checks++; if (q_a[0] !== 8'h3C) begin errors++; $display("FAIL after_reset_data: got %h want 3c", q_a[0]); end
        checks++; if (last_a !== 8'h3C) begin errors++; $display("FAIL after_reset_last: got %h want 3c", last_a); end
    endtask

    task automatic test_7n2();
        q_c.delete();
        ready_c = 1'b1;
        send_frame(2, 9'h041, 7, -1, 2, 2'b11);
        repeat (2) bit_time();
        checks++; if (q_c.size() !== 1) begin errors++; $display("FAIL 7n2_words: got %0d want 1", q_c.size()); end
        checks++; if (q_c[0] !== 7'h41) begin errors++; $display("FAIL 7n2_data: got %h want 41", q_c[0]); end
        checks++; if (last_c !== 7'h41) begin errors++; $display("FAIL 7n2_last: got %h want 41", last_c); end
        checks++; if (ferr_c !== 1'b0) begin errors++; $display("FAIL 7n2_ferr: got %b want 0", ferr_c); end
        // First stop bit high, second stop bit low.
        send_frame(2, 9'h022, 7, -1, 2, 2'b01);
        rx_c = 1'b1;
        repeat (2) bit_time();
        checks++; if (ferr_c !== 1'b1) begin errors++; $display("FAIL 7n2_stop2_ferr: got %b want 1", ferr_c); end
        checks++; if (q_c.size() !== 1) begin errors++; $display("FAIL 7n2_stop2_words: got %0d want 1", q_c.size()); end
        checks++; if (last_c !== 7'h41) begin errors++; $display("FAIL 7n2_stop2_last: got %h want 41", last_c); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_glitch_reset();
        test_7n2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
